cpu_clk_ctrl: RTL and testbench

CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

---
 rtl/cpu_clk_ctrl.sv | 128 ++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: halt, manual step, free-run and burst modes.
// Emits a registered one-cycle CPUCLKEn per CPU step and counts the steps.
module cpu_clk_ctrl #(
    parameter logic [23:0] FREE_DIV = 24'd10_000_000
) (
    input  logic        BasysCLK,
    input  logic        Reset,
    input  logic [1:0]  Mode,
    input  logic        Start,
    input  logic        StepPulse,
    input  logic [7:0]  BurstLen,
    input  logic        CPUHalt,
    output logic        CPUCLKEn,
    output logic        Running,
    output logic [1:0]  State,
    output logic [15:0] StepCount
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_MANUAL  = 2'b01,
        S_FREERUN = 2'b10,
        S_BURST   = 2'b11
    } state_t;

    localparam logic [23:0] DIV_LAST = FREE_DIV - 24'd1;
    // Enable is registered, so it is set one count early to land on DIV_LAST.
    localparam logic [23:0] DIV_PRE  = FREE_DIV - 24'd2;

    state_t      r_state;
    logic        r_en;
    logic [23:0] r_div;
    logic [7:0]  r_rem;
    logic [15:0] r_cnt;

    state_t      w_nstate;
    logic        w_en_n;
    logic [23:0] w_div_n;
    logic [7:0]  w_rem_n;
    logic        w_clr;
    logic [15:0] w_cnt_n;

    always_ff @(posedge BasysCLK) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_div   <= 24'd0;
            r_rem   <= 8'd0;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_nstate;
            r_en    <= w_en_n;
            r_div   <= w_div_n;
            r_rem   <= w_rem_n;
            r_cnt   <= w_cnt_n;
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_en_n   = 1'b0;
        w_div_n  = r_div;
        w_rem_n  = r_rem;
        w_clr    = 1'b0;
        if (r_state != S_IDLE && (CPUHalt || Mode == 2'b00)) begin
            w_nstate = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (Start && !CPUHalt) begin
                        case (Mode)
                            2'b01: begin
                                w_nstate = S_MANUAL;
                                w_clr    = 1'b1;
                            end
                            2'b10: begin
                                w_nstate = S_FREERUN;
                                w_div_n  = 24'd0;
                                w_clr    = 1'b1;
                            end
                            2'b11: begin
                                if (BurstLen != 8'd0) begin
                                    w_nstate = S_BURST;
                                    w_rem_n  = BurstLen - 8'd1;
                                    w_en_n   = 1'b1;
                                    w_clr    = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_MANUAL: w_en_n = StepPulse;
                S_FREERUN: begin
                    w_en_n  = (r_div == DIV_PRE);
                    w_div_n = (r_div == DIV_LAST) ? 24'd0 : r_div + 24'd1;
                end
                S_BURST: begin
                    if (r_rem != 8'd0) begin
                        w_en_n  = 1'b1;
                        w_rem_n = r_rem - 8'd1;
                    end else begin
                        w_nstate = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Count pulses as they retire; a new run discards any pending count.
    always_comb begin
        if (w_clr)
            w_cnt_n = 16'd0;
        else if (r_en && r_cnt != 16'hFFFF)
            w_cnt_n = r_cnt + 16'd1;
        else
            w_cnt_n = r_cnt;
    end

    always_comb begin
        State     = r_state;
        Running   = (r_state != S_IDLE);
        CPUCLKEn  = r_en;
        StepCount = r_cnt;
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl with FREE_DIV=4.
// Directed scenarios followed by random stimulus against a step-age model.
module tb_cpu_clk_ctrl;

    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  md = 2'b00;
    logic        st = 1'b0;
    logic        sp = 1'b0;
    logic [7:0]  bl = 8'd0;
    logic        halt = 1'b0;
    logic        en;
    logic        running;
    logic [1:0]  state;
    logic [15:0] cnt;

    int nchk = 0;
    int nfail = 0;

    // Model: run mode, edges since accepted start, burst length, count, next enable.
    int ms = 0;
    int age = 0;
    int mlen = 0;
    int mcnt = 0;
    bit men = 1'b0;

    cpu_clk_ctrl #(.FREE_DIV(24'd4)) dut (
        .BasysCLK (clk),
        .Reset    (rst),
        .Mode     (md),
        .Start    (st),
        .StepPulse(sp),
        .BurstLen (bl),
        .CPUHalt  (halt),
        .CPUCLKEn (en),
        .Running  (running),
        .State    (state),
        .StepCount(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int cnt_n;
        cnt_n = men ? ((mcnt == 65535) ? 65535 : mcnt + 1) : mcnt;
        if (rst) begin
            ms = 0; men = 1'b0; mcnt = 0; age = 0;
        end else begin
            if (ms != 0 && (halt || md == 2'b00)) begin
                ms = 0; men = 1'b0;
            end else if (ms == 0) begin
                men = 1'b0;
                if (st && !halt && (md == 2'b01 || md == 2'b10 || (md == 2'b11 && bl != 0))) begin
                    ms = int'(md); age = 1; mlen = int'(bl); cnt_n = 0;
                    men = (md == 2'b11);
                end
            end else begin
                age++;
                case (ms)
                    1: men = sp;
                    2: men = (age % FD == 0);
                    default: begin
                        if (age > mlen) begin ms = 0; men = 1'b0; end
                        else men = 1'b1;
                    end
                endcase
            end
            mcnt = cnt_n;
        end
    endtask

    task automatic cyc(input logic r, input logic h, input logic [1:0] m,
                       input logic s, input logic p, input logic [7:0] b);
        rst = r; halt = h; md = m; st = s; sp = p; bl = b;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("state", 32'(state), 32'(ms));
        chk("cpuclken", 32'(en), 32'(men));
        chk("running", 32'(running), 32'(ms != 0));
        chk("stepcount", 32'(cnt), 32'(mcnt));
    endtask

    task automatic idle(input int n, input logic [1:0] m);
        for (int i = 0; i < n; i++) cyc(0, 0, m, 0, 0, 8'd0);
    endtask

    initial begin
        @(negedge clk);
        cyc(1, 1, 2'b11, 1, 1, 8'd9);
        cyc(1, 0, 2'b10, 1, 0, 8'd0);
        chk("reset_cnt", 32'(cnt), 32'd0);
        idle(2, 2'b01);

        // Manual stepping and stray inputs in MANUAL
        cyc(0, 0, 2'b01, 1, 0, 8'd0);
        idle(2, 2'b01);
        cyc(0, 0, 2'b01, 0, 1, 8'd0);
        idle(6, 2'b01);
        cyc(0, 0, 2'b01, 0, 1, 8'd0);
        idle(3, 2'b01);
        chk("manual_cnt", 32'(cnt), 32'd2);
        chk("manual_state", 32'(state), 32'd1);
        cyc(0, 0, 2'b10, 1, 0, 8'd0);
        idle(2, 2'b11);
        chk("stray_start_state", 32'(state), 32'd1);
        chk("stray_start_cnt", 32'(cnt), 32'd2);
        idle(2, 2'b00);

        // Free-run with stray step pulses, then halt via Mode=00
        cyc(0, 0, 2'b10, 1, 0, 8'd0);
        for (int i = 1; i <= 20; i++) cyc(0, 0, 2'b10, 0, (i % 3 == 0), 8'd0);
        cyc(0, 0, 2'b00, 0, 0, 8'd0);
        chk("free_state", 32'(state), 32'd0);
        chk("free_cnt", 32'(cnt), 32'd5);
        idle(6, 2'b00);

        // Burst of 3, then zero-length burst
        cyc(0, 0, 2'b11, 1, 0, 8'd3);
        idle(4, 2'b11);
        chk("burst_cnt", 32'(cnt), 32'd3);
        chk("burst_running", 32'(running), 32'd0);
        cyc(0, 0, 2'b11, 1, 0, 8'd0);
        idle(2, 2'b11);
        chk("burst0_state", 32'(state), 32'd0);
        chk("burst0_cnt", 32'(cnt), 32'd3);

        // CPU halt mid-burst, start blocked while halted
        cyc(0, 0, 2'b11, 1, 0, 8'd200);
        idle(4, 2'b11);
        cyc(0, 1, 2'b11, 0, 0, 8'd200);
        chk("halt_state", 32'(state), 32'd0);
        chk("halt_cnt", 32'(cnt), 32'd5);
        cyc(0, 1, 2'b11, 0, 0, 8'd200);
        cyc(0, 1, 2'b11, 0, 0, 8'd200);
        cyc(0, 1, 2'b11, 1, 0, 8'd200);
        idle(2, 2'b11);
        chk("halt_start_ignored", 32'(state), 32'd0);

        // Reset mid free-run
        cyc(0, 0, 2'b10, 1, 0, 8'd0);
        idle(6, 2'b10);
        cyc(1, 0, 2'b10, 1, 1, 8'd5);
        chk("midrun_rst_en", 32'(en), 32'd0);
        chk("midrun_rst_cnt", 32'(cnt), 32'd0);
        idle(3, 2'b10);

        // Saturation
        cyc(0, 0, 2'b01, 1, 0, 8'd0);
        force dut.r_cnt = 16'hFFFE;
        #1 release dut.r_cnt;
        mcnt = 65534;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 2'b01, 0, 1, 8'd0);
            cyc(0, 0, 2'b01, 0, 0, 8'd0);
        end
        idle(2, 2'b01);
        chk("saturate", 32'(cnt), 32'hFFFF);
        cyc(1, 0, 2'b00, 0, 0, 8'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic r, h, s, p;
            logic [1:0] m;
            logic [7:0] b;
            r = ($urandom_range(0, 99) == 0);
            h = ($urandom_range(0, 39) == 0);
            m = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            s = ($urandom_range(0, 5) == 0);
            p = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            cyc(r, h, m, s, p, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
